// File: rtl/squareroot_ahsqr_k8_if.sv
// Streaming radicand-in / root-out bundle for the AHSQR square-root block.
// The master drives radicands and in_valid. The slave returns roots and out_valid.
interface squareroot_ahsqr_k8_if #(
  parameter int W = 16
);
  logic             in_valid;
  logic [W-1:0]     R;
  logic             out_valid;
  logic [W/2-1:0]   final_op;

  modport master (
    output in_valid,
    output R,
    input  out_valid,
    input  final_op
  );

  modport slave (
    input  in_valid,
    input  R,
    output out_valid,
    output final_op
  );
endinterface

// File: rtl/squareroot_ahsqr_k8.sv
// Approximate hybrid integer square root, truncation depth K.
// Radicands whose bits above K are all zero get an exact root.
// For larger radicands, the K low bits are forced to the midpoint 2^(K-1) before the
// exact root is taken.
// Two register stages: the input register, then the output register.
// The root engine is purely combinational and sits between the two stages.
module squareroot_ahsqr_k8 #(
  parameter int W = 16,
  parameter int K = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  squareroot_ahsqr_k8_if.slave bus
);

  localparam int HW = W / 2;
  localparam int EW = W + 2;

  logic [W-1:0]  r_q;
  logic          v1_q;
  logic [W-1:0]  rad;
  logic [EW-1:0] rem;
  logic [EW-1:0] trial;
  logic [HW-1:0] root;

  // Stage 1: capture the radicand and its valid flag every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      r_q  <= bus.R;
      v1_q <= bus.in_valid;
    end
  end

  // Hybrid select: keep small radicands intact; otherwise replace the low K bits
  // with the midpoint.
  always_comb begin
    rad = '0;
    if (r_q[W-1:K] == '0) begin
      rad = {{(W-K){1'b0}}, r_q[K-1:0]};
    end else begin
      rad = {r_q[W-1:K], 1'b1, {(K-1){1'b0}}};
    end
  end

  // Exact restoring digit-by-digit root, fully unrolled.
  // rem carries two spare bits so that no trial subtraction can wrap.
  always_comb begin
    rem   = {2'b00, rad};
    root  = '0;
    trial = '0;
    for (int i = HW - 1; i >= 0; i--) begin
      trial = (({{(EW-HW){1'b0}}, root} << 1) + (EW'(1) << i)) << i;
      if (rem >= trial) begin
        rem  = rem - trial;
        root = root | (HW'(1) << i);
      end
    end
  end

  // Stage 2: register the root. out_valid trails in_valid by exactly two clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.final_op  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.final_op  <= root;
      bus.out_valid <= v1_q;
    end
  end

endmodule

// File: tb/tb_squareroot_ahsqr_k8.sv
// Bench for squareroot_ahsqr_k8.
// Each accepted radicand is paired with its due cycle and expected root in a queue.
// Expected roots come from the hybrid formula and an integer square-root search.
module tb_squareroot_ahsqr_k8;

  logic clk;
  logic rst_n;

  squareroot_ahsqr_k8_if #(.W(16)) bus ();

  squareroot_ahsqr_k8 #(.W(16), .K(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int r;
    int exp;
  } ent_t;

  ent_t q[$];
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_err   = 0;
  int   max_err = 0;

  int dir_r [10] = '{'h0000, 'h0010, 'h00FF, 'h00C8, 'h0100,
                     'h4000, 'hD399, 'h8000, 'hFFFF, 'hFF80};
  int dir_e [10] = '{0, 4, 15, 14, 19, 128, 232, 181, 255, 255};

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int s = 0;
    for (int b = 7; b >= 0; b--) begin
      if ((s | (1 << b)) * (s | (1 << b)) <= x) s = s | (1 << b);
    end
    return s;
  endfunction

  function automatic int ref_root(input int r);
    if ((r >> 8) == 0) return isqrt(r);
    return isqrt((r & 'hFF00) | 'h80);
  endfunction

  task automatic score();
    ent_t e;
    bit   ev;
    int   d;
    while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
    ev = (q.size() > 0) && (q[0].due == cyc);
    check("out_valid", int'(bus.out_valid), int'(ev));
    if (ev) begin
      e = q.pop_front();
      check($sformatf("final_op R=%04h", e.r), int'(bus.final_op), e.exp);
      if (e.r >= 256) begin
        d = int'(bus.final_op) - isqrt(e.r);
        if (d < 0) d = -d;
        if (d > max_err) max_err = d;
      end
    end
  endtask

  // expv < 0 selects the reference model; otherwise it is a fixed expected root.
  task automatic step(input logic v, input logic [15:0] r, input int expv);
    @(negedge clk);
    cyc++;
    score();
    bus.in_valid = v;
    bus.R        = r;
    if (v) q.push_back('{cyc + 2, int'(r), (expv < 0) ? ref_root(int'(r)) : expv});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), -1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_async_valid", int'(bus.out_valid), 0);
    check("rst_async_root", int'(bus.final_op), 0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      check("rst_valid", int'(bus.out_valid), 0);
      check("rst_root", int'(bus.final_op), 0);
      bus.in_valid = 1'b1;
      bus.R        = 16'($urandom);
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.R        = '0;
    do_reset(4);
    idle(3);

    for (int i = 0; i < 10; i++) step(1'b1, 16'(dir_r[i]), dir_e[i]);
    idle(4);

    step(1'b1, 16'hD399, 232);
    step(1'b1, 16'h00FF, 15);
    step(1'b1, 16'hFFFF, 255);
    idle(3);

    step(1'b1, 16'hFFFF, -1);
    step(1'b1, 16'h4000, -1);
    do_reset(3);
    idle(3);
    step(1'b1, 16'h0010, 4);
    idle(3);

    for (int r = 0; r < 65536; r++) step(1'b1, 16'(r), -1);

    for (int i = 0; i < 2000; i++) step(1'($urandom_range(0, 1)), 16'($urandom), -1);
    idle(4);

    check("drain", q.size(), 0);
    check("max_abs_err", max_err, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
